// File: rtl/mb_add_pkg.sv
// Shared types and constants for the multi-byte serial adder sequencer.
package mb_add_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Byte counter width; at least one bit so NBYTES=1 still has a counter.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mb_add_seq_add8_cin.sv
// 8-bit ripple adder with carry-in, built from a chain of single-bit full adders.
module bit_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add8_cin (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   logic [8:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < 8; i++) begin : g_bit
      bit_adder u_bit (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .sum  (sum[i]),
         .cout (carry[i+1])
      );
   end

   assign cout = carry[8];
endmodule

// File: rtl/mb_add_seq.sv
// Multi-byte serial adder: one shared 8-bit adder walks the operands LSB byte first.
//  state   | meaning
//  IDLE    | waiting for an operand pair, in_ready high
//  RUN     | adding one byte per cycle, NBYTES cycles
//  DONE    | result valid, waiting for out_ready
module mb_add_seq
   import mb_add_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NBYTES*BYTE_W-1:0]   a_in,
   input  logic [NBYTES*BYTE_W-1:0]   b_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NBYTES*BYTE_W-1:0]   sum_out,
   output logic                       carry_out,
   output logic                       busy
);
   localparam int W     = NBYTES * BYTE_W;
   localparam int IDX_W = idx_w(NBYTES);
   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NBYTES - 1);

   state_t              state, state_nxt;
   logic [W-1:0]        a_q, b_q, sum_q;
   logic                carry_q;
   logic [IDX_W-1:0]    cnt_q;
   logic [BYTE_W-1:0]   sum_byte;
   logic                cout_byte;
   logic [W+BYTE_W-1:0] sum_shift;
   logic                accept;
   logic                last_byte;

   assign accept    = in_valid && in_ready;
   assign last_byte = (cnt_q == '0);
   assign busy      = (state != ST_IDLE);
   assign sum_out   = sum_q;
   assign carry_out = carry_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // in_ready is gated by rst_n so it stays low for the whole reset window.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         ST_IDLE: begin
            in_ready = rst_n;
            if (in_valid && rst_n) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (last_byte) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   add8_cin u_add (
      .a    (a_q[BYTE_W-1:0]),
      .b    (b_q[BYTE_W-1:0]),
      .cin  (carry_q),
      .sum  (sum_byte),
      .cout (cout_byte)
   );

   // Operands shift right and the sum shifts in from the top, so after
   // NBYTES steps the first byte computed sits in the LSB position.
   assign sum_shift = {sum_byte, sum_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         a_q     <= a_in;
         b_q     <= b_in;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= LAST_CNT;
      end else if (state == ST_RUN) begin
         a_q     <= a_q >> BYTE_W;
         b_q     <= b_q >> BYTE_W;
         sum_q   <= sum_shift[W+BYTE_W-1:BYTE_W];
         carry_q <= cout_byte;
         if (!last_byte) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_mb_add_seq.sv
// Directed and random checks of mb_add_seq against a plain-arithmetic reference.
module tb_mb_add_seq;
   localparam int NB = 4;
   localparam int W  = NB * 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_in, b_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum_out;
   logic         carry_out;
   logic         busy;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   mb_add_seq #(.NBYTES(NB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum_out   (sum_out),
      .carry_out (carry_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present an operand pair, wait for the accept edge, then scramble the
   // operand inputs to prove they are ignored during RUN.
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit keep_valid, output int t);
      int n;
      n = 0;
      a_in = a;
      b_in = b;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", 64'(n < 100), 64'd1);
      @(posedge clk);
      @(negedge clk);
      t = cyc;
      check("in_ready_run", in_ready, 1'b0);
      check("busy_run", busy, 1'b1);
      check("ov_run", out_valid, 1'b0);
      if (!keep_valid) in_valid = 1'b0;
      a_in = $urandom;
      b_in = $urandom;
   endtask

   task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b,
                              input int t, input int hold);
      logic [W:0] r;
      int n;
      r = {1'b0, a} + {1'b0, b};
      n = 0;
      out_ready = (hold == 0);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("latency", 64'(cyc - t), 64'(NB));
      check("sum", sum_out, r[W-1:0]);
      check("carry", carry_out, r[W]);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1'b1);
         check("hold_sum", sum_out, r[W-1:0]);
         check("hold_carry", carry_out, r[W]);
         check("hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("ov_drop", out_valid, 1'b0);
      check("in_ready_idle", in_ready, 1'b1);
      check("sum_keep", sum_out, r[W-1:0]);
   endtask

   initial begin
      logic [W-1:0] ra, rb, na, nb;
      int t, t_prev;

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a_in = '0;
      b_in = '0;
      #3;
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sum", sum_out, '0);
      check("rst_carry", carry_out, 1'b0);
      check("rst_busy", busy, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);
      check("post_rst_busy", busy, 1'b0);

      // carry ripple across a byte boundary
      accept(32'h0000_00FF, 32'h0000_0001, 1'b0, t);
      wait_result(32'h0000_00FF, 32'h0000_0001, t, 0);
      // full wrap
      accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, t);
      wait_result(32'hFFFF_FFFF, 32'h0000_0001, t, 0);
      accept(32'h1234_5678, 32'h8765_4321, 1'b0, t);
      wait_result(32'h1234_5678, 32'h8765_4321, t, 0);
      accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, t);
      wait_result(32'hFFFF_FFFF, 32'hFFFF_FFFF, t, 0);

      // backpressure
      accept(32'h8000_0000, 32'h8000_0000, 1'b0, t);
      wait_result(32'h8000_0000, 32'h8000_0000, t, 5);

      // operand change during RUN
      accept(32'd1, 32'd2, 1'b0, t);
      @(negedge clk);
      a_in = 32'hDEAD_BEEF;
      b_in = 32'hDEAD_BEEF;
      wait_result(32'd1, 32'd2, t, 0);

      // back-to-back with in_valid held high
      ra = $urandom;
      rb = $urandom;
      accept(ra, rb, 1'b1, t);
      for (int i = 0; i < 4; i++) begin
         t_prev = t;
         wait_result(ra, rb, t, 0);
         na = $urandom;
         nb = $urandom;
         accept(na, nb, 1'b1, t);
         check("b2b_spacing", 64'(t - t_prev), 64'(NB + 2));
         ra = na;
         rb = nb;
      end
      in_valid = 1'b0;
      wait_result(ra, rb, t, 0);

      // reset mid-RUN at byte index 2
      accept(32'hAAAA_5555, 32'h1111_2222, 1'b0, t);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_sum", sum_out, '0);
      check("abort_carry", carry_out, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_in_ready", in_ready, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("no_ov_after_abort", out_valid, 1'b0);
      end
      accept(32'd5, 32'd7, 1'b0, t);
      wait_result(32'd5, 32'd7, t, 0);

      // random operands with random backpressure
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         accept(ra, rb, 1'b0, t);
         wait_result(ra, rb, t, int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
